// File: rtl/dphy_pkg.sv
// Shared types and constants for the D-PHY lane-to-word packer.
package dphy_pkg;

    localparam int unsigned MAX_LANES        = 8;
    localparam int unsigned LANE_CNT_W       = 4;  // holds 0..MAX_LANES
    localparam int unsigned OUT_BYTES_NARROW = 4;
    localparam int unsigned OUT_BYTES_WIDE   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        FLUSH = 2'd2
    } packer_state_t;

    // True when the output word width is one of the supported sizes.
    function automatic logic legal_out_bytes(input int unsigned ob);
        return (ob == OUT_BYTES_NARROW) || (ob == OUT_BYTES_WIDE);
    endfunction

endpackage

// File: rtl/lane_mask_decode.sv
// Counts valid lanes and flags whether the mask is contiguous from lane 0.
module lane_mask_decode
    import dphy_pkg::*;
#(
    parameter int unsigned DATA_LANES = 4
) (
    input  logic [DATA_LANES-1:0] lane_valid_i,
    output logic [LANE_CNT_W-1:0] cnt_c,
    output logic                  contig_c
);

    logic [LANE_CNT_W-1:0] cnt;
    logic [DATA_LANES-1:0] exp_mask;

    // Population count, then compare against the ideal mask for that count.
    always_comb begin
        cnt      = '0;
        exp_mask = '0;
        for (int unsigned i = 0; i < DATA_LANES; i++) begin
            cnt = cnt + LANE_CNT_W'(lane_valid_i[i]);
        end
        for (int unsigned i = 0; i < DATA_LANES; i++) begin
            exp_mask[i] = (LANE_CNT_W'(i) < cnt);
        end
        cnt_c    = cnt;
        contig_c = (lane_valid_i == exp_mask);
    end

endmodule

// File: rtl/dphy_word_packer.sv
// Packs per-lane D-PHY bytes into gap-free OUT_BYTES words with keep/last.
module dphy_word_packer
    import dphy_pkg::*;
#(
    parameter int unsigned DATA_LANES = 4,
    parameter int unsigned OUT_BYTES  = 4
) (
    input  logic                    byte_clk_i,
    input  logic                    rst_i,
    input  logic [DATA_LANES*8-1:0] lane_data_i,
    input  logic [DATA_LANES-1:0]   lane_valid_i,
    input  logic                    eop_i,
    output logic [OUT_BYTES*8-1:0]  data_o,
    output logic [OUT_BYTES-1:0]    keep_o,
    output logic                    valid_o,
    output logic                    last_o,
    output logic                    err_o
);

    localparam int unsigned ACC_BYTES = OUT_BYTES + DATA_LANES - 1;
    localparam int unsigned FILL_W    = $clog2(OUT_BYTES + DATA_LANES);
    localparam logic [FILL_W-1:0] OUT_FILL = FILL_W'(OUT_BYTES);

    // Reject unsupported lane/word combinations at elaboration.
    if (DATA_LANES < 1 || DATA_LANES > MAX_LANES || !legal_out_bytes(OUT_BYTES) ||
        DATA_LANES > OUT_BYTES) begin : g_param_check
        $fatal(1, "dphy_word_packer: illegal DATA_LANES/OUT_BYTES combination");
    end

    packer_state_t           state_q, state_d;
    logic [FILL_W-1:0]       fill_q, fill_d, n_eff, total;
    logic [ACC_BYTES*8-1:0]  acc_q, acc_d, lane_ext, merged;
    logic [OUT_BYTES*8-1:0]  data_d;
    logic [OUT_BYTES-1:0]    keep_d;
    logic                    valid_d, last_d, err_d;
    logic [LANE_CNT_W-1:0]   cnt_c;
    logic                    contig_c;

    lane_mask_decode #(.DATA_LANES(DATA_LANES)) u_decode (
        .lane_valid_i (lane_valid_i),
        .cnt_c        (cnt_c),
        .contig_c     (contig_c)
    );

    // Low k bits set; used for partial final words.
    function automatic logic [OUT_BYTES-1:0] keep_of(input logic [FILL_W-1:0] k);
        logic [OUT_BYTES-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < OUT_BYTES; i++) begin
            m[i] = (FILL_W'(i) < k);
        end
        return m;
    endfunction

    // State register.
    always_ff @(posedge byte_clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state, accumulator update and next output word.
    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        acc_d    = acc_q;
        data_d   = '0;
        keep_d   = '0;
        valid_d  = 1'b0;
        last_d   = 1'b0;
        err_d    = !contig_c || (state_q == FLUSH && (cnt_c != '0 || eop_i));
        n_eff    = (contig_c && state_q != FLUSH) ? FILL_W'(cnt_c) : '0;
        total    = fill_q + n_eff;
        lane_ext = '0;
        for (int unsigned j = 0; j < DATA_LANES; j++) begin
            if (FILL_W'(j) < n_eff) lane_ext[j*8 +: 8] = lane_data_i[j*8 +: 8];
        end
        // Accumulator bytes above fill_q are always zero, so OR-in is safe.
        merged = acc_q | (lane_ext << {fill_q, 3'b000});

        if (state_q == FLUSH) begin
            data_d  = acc_q[OUT_BYTES*8-1:0];
            keep_d  = keep_of(fill_q);
            valid_d = 1'b1;
            last_d  = 1'b1;
            acc_d   = '0;
            fill_d  = '0;
            state_d = IDLE;
        end else if (eop_i) begin
            acc_d   = '0;
            fill_d  = '0;
            state_d = IDLE;
            if (total > OUT_FILL) begin
                data_d  = merged[OUT_BYTES*8-1:0];
                keep_d  = '1;
                valid_d = 1'b1;
                acc_d   = merged >> (OUT_BYTES*8);
                fill_d  = total - OUT_FILL;
                state_d = FLUSH;
            end else if (total != '0) begin
                data_d  = merged[OUT_BYTES*8-1:0];
                keep_d  = keep_of(total);
                valid_d = 1'b1;
                last_d  = 1'b1;
            end
        end else if (total >= OUT_FILL) begin
            data_d  = merged[OUT_BYTES*8-1:0];
            keep_d  = '1;
            valid_d = 1'b1;
            acc_d   = merged >> (OUT_BYTES*8);
            fill_d  = total - OUT_FILL;
            state_d = ACC;
        end else begin
            acc_d  = merged;
            fill_d = total;
            if (total != '0) state_d = ACC;
        end
    end

    // Accumulator and registered outputs.
    always_ff @(posedge byte_clk_i) begin
        if (rst_i) begin
            acc_q   <= '0;
            fill_q  <= '0;
            data_o  <= '0;
            keep_o  <= '0;
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            data_o  <= data_d;
            keep_o  <= keep_d;
            valid_o <= valid_d;
            last_o  <= last_d;
            err_o   <= err_d;
        end
    end

endmodule

// File: tb/tb_dphy_word_packer.sv
// Directed bench for dphy_word_packer in three lane/word configurations.
module tb_dphy_word_packer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] d44;  logic [3:0] m44;  logic e44;
    logic [31:0] od44; logic [3:0] ok44; logic ov44, ol44, oe44;
    logic [23:0] d34;  logic [2:0] m34;  logic e34;
    logic [31:0] od34; logic [3:0] ok34; logic ov34, ol34, oe34;
    logic [15:0] d28;  logic [1:0] m28;  logic e28;
    logic [63:0] od28; logic [7:0] ok28; logic ov28, ol28, oe28;

    int checks = 0;
    int errors = 0;

    dphy_word_packer #(.DATA_LANES(4), .OUT_BYTES(4)) u_44 (
        .byte_clk_i(clk), .rst_i(rst), .lane_data_i(d44), .lane_valid_i(m44), .eop_i(e44),
        .data_o(od44), .keep_o(ok44), .valid_o(ov44), .last_o(ol44), .err_o(oe44));
    dphy_word_packer #(.DATA_LANES(3), .OUT_BYTES(4)) u_34 (
        .byte_clk_i(clk), .rst_i(rst), .lane_data_i(d34), .lane_valid_i(m34), .eop_i(e34),
        .data_o(od34), .keep_o(ok34), .valid_o(ov34), .last_o(ol34), .err_o(oe34));
    dphy_word_packer #(.DATA_LANES(2), .OUT_BYTES(8)) u_28 (
        .byte_clk_i(clk), .rst_i(rst), .lane_data_i(d28), .lane_valid_i(m28), .eop_i(e28),
        .data_o(od28), .keep_o(ok28), .valid_o(ov28), .last_o(ol28), .err_o(oe28));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_word(input string tag,
                               input logic ov, input logic ol, input logic [63:0] ok,
                               input logic [63:0] od, input logic oe,
                               input logic v, input logic l, input logic [63:0] k,
                               input logic [63:0] d, input logic e);
        check({tag, ".valid"}, 64'(ov), 64'(v));
        check({tag, ".last"},  64'(ol), 64'(l));
        check({tag, ".err"},   64'(oe), 64'(e));
        if (v) begin
            check({tag, ".keep"}, ok, k);
            check({tag, ".data"}, od, d);
        end
    endtask

    task automatic x44(input string t, input logic v, input logic l, input logic [3:0] k,
                       input logic [31:0] d, input logic e);
        expect_word(t, ov44, ol44, 64'(ok44), 64'(od44), oe44, v, l, 64'(k), 64'(d), e);
    endtask
    task automatic x34(input string t, input logic v, input logic l, input logic [3:0] k,
                       input logic [31:0] d, input logic e);
        expect_word(t, ov34, ol34, 64'(ok34), 64'(od34), oe34, v, l, 64'(k), 64'(d), e);
    endtask
    task automatic x28(input string t, input logic v, input logic l, input logic [7:0] k,
                       input logic [63:0] d, input logic e);
        expect_word(t, ov28, ol28, 64'(ok28), od28, oe28, v, l, 64'(k), d, e);
    endtask

    task automatic beat44(input logic [31:0] d, input logic [3:0] m, input logic e);
        d44 = d; m44 = m; e44 = e;
        @(posedge clk); #1;
        d44 = '0; m44 = '0; e44 = 1'b0;
    endtask
    task automatic beat34(input logic [23:0] d, input logic [2:0] m, input logic e);
        d34 = d; m34 = m; e34 = e;
        @(posedge clk); #1;
        d34 = '0; m34 = '0; e34 = 1'b0;
    endtask
    task automatic beat28(input logic [15:0] d, input logic [1:0] m, input logic e);
        d28 = d; m28 = m; e28 = e;
        @(posedge clk); #1;
        d28 = '0; m28 = '0; e28 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        d44 = '0; m44 = '0; e44 = 1'b0;
        d34 = '0; m34 = '0; e34 = 1'b0;
        d28 = '0; m28 = '0; e28 = 1'b0;
        @(posedge clk); @(posedge clk); #1;

        // Reset state: everything cleared.
        check("rst.d44", 64'(od44), 64'h0); check("rst.k44", 64'(ok44), 64'h0);
        check("rst.d34", 64'(od34), 64'h0); check("rst.k34", 64'(ok34), 64'h0);
        check("rst.d28", od28, 64'h0);      check("rst.k28", 64'(ok28), 64'h0);
        x44("rst44", 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
        x34("rst34", 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
        x28("rst28", 1'b0, 1'b0, 8'h0, 64'h0, 1'b0);
        rst = 1'b0;

        // 4 lanes -> 4-byte words, one word per beat.
        beat44(32'h03020100, 4'hF, 1'b0); x44("a.w0", 1'b1, 1'b0, 4'hF, 32'h03020100, 1'b0);
        beat44(32'h07060504, 4'hF, 1'b0); x44("a.w1", 1'b1, 1'b0, 4'hF, 32'h07060504, 1'b0);
        beat44(32'h0B0A0908, 4'hF, 1'b0); x44("a.w2", 1'b1, 1'b0, 4'hF, 32'h0B0A0908, 1'b0);
        beat44(32'h0F0E0D0C, 4'hF, 1'b1); x44("a.w3", 1'b1, 1'b1, 4'hF, 32'h0F0E0D0C, 1'b0);
        beat44(32'h0, 4'h0, 1'b0);        x44("a.idle", 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);

        // 3 lanes -> 4-byte words across boundaries.
        beat34(24'h020100, 3'b111, 1'b0); x34("b.b0", 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
        beat34(24'h050403, 3'b111, 1'b0); x34("b.w0", 1'b1, 1'b0, 4'hF, 32'h03020100, 1'b0);
        beat34(24'h080706, 3'b111, 1'b0); x34("b.w1", 1'b1, 1'b0, 4'hF, 32'h07060504, 1'b0);
        beat34(24'h0B0A09, 3'b111, 1'b1); x34("b.w2", 1'b1, 1'b1, 4'hF, 32'h0B0A0908, 1'b0);
        beat34(24'h0, 3'b000, 1'b0);      x34("b.idle", 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);

        // 7 bytes, partial final word; unused lanes carry junk.
        beat34(24'h020100, 3'b111, 1'b0); x34("c.b0", 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
        beat34(24'hAA0403, 3'b011, 1'b0); x34("c.w0", 1'b1, 1'b0, 4'hF, 32'h03020100, 1'b0);
        beat34(24'hBB0605, 3'b011, 1'b1); x34("c.w1", 1'b1, 1'b1, 4'h7, 32'h00060504, 1'b0);
        beat34(24'h0, 3'b000, 1'b0);      x34("c.idle", 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);

        // F=3 then full beat with eop: full word, then FLUSH remainder.
        beat44(32'hEE020100, 4'h7, 1'b0); x44("d.b0", 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
        beat44(32'h06050403, 4'hF, 1'b1); x44("d.w0", 1'b1, 1'b0, 4'hF, 32'h03020100, 1'b0);
        beat44(32'h0, 4'h0, 1'b0);        x44("d.w1", 1'b1, 1'b1, 4'h7, 32'h00060504, 1'b0);
        beat44(32'h0, 4'h0, 1'b0);        x44("d.idle", 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);

        // 2 lanes -> 8 bytes: non-contiguous mask is an error with no output.
        beat28(16'h1234, 2'b10, 1'b0);    x28("e.ncont", 1'b0, 1'b0, 8'h0, 64'h0, 1'b1);
        beat28(16'h0, 2'b00, 1'b0);       x28("e.idle", 1'b0, 1'b0, 8'h0, 64'h0, 1'b0);

        // Non-contiguous beat with eop: beat dropped, eop still closes packet.
        beat28(16'h0100, 2'b11, 1'b0);    x28("f.b0", 1'b0, 1'b0, 8'h0, 64'h0, 1'b0);
        beat28(16'hCC00, 2'b10, 1'b1);    x28("f.w0", 1'b1, 1'b1, 8'h03, 64'h0100, 1'b1);

        // F=7 then 2 bytes + eop -> FLUSH; a beat during FLUSH is an error and dropped.
        beat28(16'h0100, 2'b11, 1'b0);    x28("g.b0", 1'b0, 1'b0, 8'h0, 64'h0, 1'b0);
        beat28(16'h0302, 2'b11, 1'b0);    x28("g.b1", 1'b0, 1'b0, 8'h0, 64'h0, 1'b0);
        beat28(16'h0504, 2'b11, 1'b0);    x28("g.b2", 1'b0, 1'b0, 8'h0, 64'h0, 1'b0);
        beat28(16'hEE06, 2'b01, 1'b0);    x28("g.b3", 1'b0, 1'b0, 8'h0, 64'h0, 1'b0);
        beat28(16'h0807, 2'b11, 1'b1);    x28("g.w0", 1'b1, 1'b0, 8'hFF, 64'h0706050403020100, 1'b0);
        beat28(16'hBBAA, 2'b11, 1'b0);    x28("g.w1", 1'b1, 1'b1, 8'h01, 64'h08, 1'b1);
        beat28(16'h0, 2'b00, 1'b0);       x28("g.idle", 1'b0, 1'b0, 8'h0, 64'h0, 1'b0);
        beat28(16'h0055, 2'b01, 1'b1);    x28("g.fresh", 1'b1, 1'b1, 8'h01, 64'h55, 1'b0);

        // Reset with F=2 open: drops bytes, fresh packet starts at byte 0.
        beat44(32'hAAAA0201, 4'h3, 1'b0); x44("h.b0", 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
        rst = 1'b1;
        beat44(32'h06050403, 4'hF, 1'b0);
        rst = 1'b0;
        check("h.rst.d44", 64'(od44), 64'h0); check("h.rst.k44", 64'(ok44), 64'h0);
        x44("h.rst", 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
        beat44(32'h13121110, 4'hF, 1'b1); x44("h.w0", 1'b1, 1'b1, 4'hF, 32'h13121110, 1'b0);
        beat44(32'h0, 4'h0, 1'b0);        x44("h.idle", 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
